// File: rtl/jam_pkg.sv
// jam_pkg: shared constants and types for the job-assignment engine slice.
//   N       matrix dimension (workers = jobs = 8, so W/J are 3 bits)
//   COST_W  width of one cost word
//   LB_W    width of the lower-bound accumulator (8 * 127 = 1016 fits)
//   IDX_W   width of the flat row-major load index (W*8+J)
//   state_e cost-table load state
package jam_pkg;

  localparam int N      = 8;
  localparam int COST_W = 7;
  localparam int LB_W   = 10;
  localparam int IDX_W  = 6;

  typedef enum logic {
    LOAD  = 1'b0,
    READY = 1'b1
  } state_e;

  function automatic logic [COST_W-1:0] cost_min(input logic [COST_W-1:0] a,
                                                 input logic [COST_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/jam_cost_table.sv
// jam_cost_table: cost-storage stage for the job-assignment engine.
// Loads the 8x8 worker/job cost matrix from a valid/ready word stream
// (row-major, W outer, J inner), serves Cost combinationally for the
// engine's W/J pair, and accumulates a lower bound on the total cost as
// the sum of the per-worker row minima while the words stream in.
//
// Ports
//   CLK          clock, rising edge
//   RST          asynchronous, active-high reset
//   in_valid     in_data carries a cost word
//   in_ready     table accepts a word this cycle (LOAD and no reload)
//   in_data      cost word
//   reload       single-cycle pulse: restart loading from index 0
//   W, J         worker / job read address
//   Cost         mem[W*8+J], combinational
//   table_ready  all 64 words loaded
//   LowerBound   sum of the 8 row minima, meaningful while table_ready
module jam_cost_table
  import jam_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [COST_W-1:0] in_data,
  input  logic              reload,
  input  logic [2:0]        W,
  input  logic [2:0]        J,
  output logic [COST_W-1:0] Cost,
  output logic              table_ready,
  output logic [LB_W-1:0]   LowerBound
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N * N - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q;
  logic [COST_W-1:0]  row_min_q;
  logic [LB_W-1:0]    lb_q;
  logic [COST_W-1:0]  mem [N*N];

  logic               xfer;
  logic [2:0]         cur_j;
  logic [COST_W-1:0]  run_min;

  assign in_ready = (state_q == LOAD) && !reload;
  assign xfer     = in_valid && in_ready;
  assign cur_j    = idx_q[2:0];
  // Minimum of the row so far including the word being accepted now;
  // at J==0 the previous row's minimum must not leak in.
  assign run_min  = (cur_j == 3'd0) ? in_data : cost_min(row_min_q, in_data);

  // State register.
  // NOTE: sequential state is assigned with non-blocking (<=) so every
  // flop samples the pre-edge values regardless of block ordering.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= LOAD;
    else     state_q <= state_d;
  end

  // Next-state logic.
  // NOTE: state_d is given a default before any branch so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD:  if (xfer && idx_q == LAST_IDX) state_d = READY;
      READY: state_d = READY;
    endcase
    if (reload) state_d = LOAD;
  end

  // Load index, row-minimum tracker and lower-bound accumulator.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      idx_q     <= '0;
      row_min_q <= '0;
      lb_q      <= '0;
    end else if (reload) begin
      idx_q <= '0;
      lb_q  <= '0;
    end else if (xfer) begin
      idx_q     <= idx_q + 1'b1;  // wraps to 0 after word 63
      row_min_q <= run_min;
      if (cur_j == 3'd7)
        lb_q <= lb_q + {{(LB_W-COST_W){1'b0}}, run_min};
    end
  end

  // Cost register file.
  // NOTE: the array is reset because Cost is architecturally 0 after RST
  // and reads are allowed on a partially loaded table; reload deliberately
  // does not clear it.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < N * N; i++) mem[i] <= '0;
    end else if (xfer) begin
      mem[idx_q] <= in_data;
    end
  end

  assign Cost        = mem[{W, J}];
  assign table_ready = (state_q == READY);
  assign LowerBound  = lb_q;

endmodule

// File: tb/tb_jam_cost_table.sv
// Self-checking bench for jam_cost_table. Stimulus pushes expected values
// into a scoreboard queue and raises probe_valid; an independent monitor
// pops and compares on the falling edge.
module tb_jam_cost_table;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [6:0] in_data = '0;
  logic       reload = 1'b0;
  logic [2:0] W = '0;
  logic [2:0] J = '0;
  logic [6:0] Cost;
  logic       table_ready;
  logic [9:0] LowerBound;

  jam_cost_table dut (
    .CLK        (CLK),
    .RST        (RST),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .reload     (reload),
    .W          (W),
    .J          (J),
    .Cost       (Cost),
    .table_ready(table_ready),
    .LowerBound (LowerBound)
  );

  always #5 CLK = ~CLK;

  localparam int K_COST = 0, K_LB = 1, K_TRDY = 2, K_IRDY = 3;

  typedef struct {
    int    kind;
    int    exp;
    string name;
  } exp_t;

  exp_t sb[$];
  logic probe_valid = 1'b0;
  int   n_pass  = 0;
  int   n_total = 0;

  // Monitor: compares whatever the stimulus announced for this cycle.
  always @(negedge CLK) begin
    if (probe_valid) begin
      exp_t e;
      int   act;
      n_total++;
      if (sb.size() == 0) begin
        $display("FAIL scoreboard_underflow: got probe with no expected entry, need one");
      end else begin
        e = sb.pop_front();
        case (e.kind)
          K_COST:  act = int'(Cost);
          K_LB:    act = int'(LowerBound);
          K_TRDY:  act = int'(table_ready);
          default: act = int'(in_ready);
        endcase
        if (act == e.exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", e.name, act, e.exp);
      end
    end
  end

  // All stimulus changes at posedge+1; each probe occupies one cycle.
  task automatic probe(input int kind, input int exp, input string name,
                       input int w = 0, input int j = 0);
    exp_t e;
    e.kind = kind; e.exp = exp; e.name = name;
    sb.push_back(e);
    W = 3'(w);
    J = 3'(j);
    probe_valid = 1'b1;
    @(posedge CLK); #1;
    probe_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  // Offer one word and wait (bounded) for the handshake.
  task automatic send(input int d);
    bit done = 0;
    in_valid = 1'b1;
    in_data  = 7'(d);
    for (int t = 0; t < 50 && !done; t++) begin
      @(negedge CLK);
      if (in_ready) begin
        @(posedge CLK); #1;
        done = 1;
      end else begin
        @(posedge CLK); #1;
      end
    end
    in_valid = 1'b0;
    if (!done) begin
      n_total++;
      $display("FAIL send_timeout: word %0d not accepted within 50 cycles, need handshake", d);
    end
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    @(posedge CLK); #1;
    reload = 1'b0;
  endtask

  function automatic int ramp(input int i);
    return i;
  endfunction

  function automatic int diag(input int i);
    return ((i >> 3) == (i & 7)) ? (i >> 3) + 1 : 127;
  endfunction

  initial begin
    #12 RST = 1'b0;
    @(posedge CLK); #1;

    // Reset state.
    probe(K_IRDY, 1, "rst_in_ready");
    probe(K_TRDY, 0, "rst_table_ready");
    probe(K_LB,   0, "rst_lower_bound");
    probe(K_COST, 0, "rst_cost_3_5", 3, 5);

    // Ramp load, back-to-back.
    for (int i = 0; i < 64; i++) send(ramp(i));
    probe(K_TRDY, 1,   "ramp_table_ready");
    probe(K_LB,   224, "ramp_lower_bound");
    probe(K_COST, 29,  "ramp_cost_3_5", 3, 5);
    probe(K_COST, 63,  "ramp_cost_7_7", 7, 7);

    // READY lockout: words offered but never accepted.
    in_valid = 1'b1;
    in_data  = 7'd127;
    idle(20);
    probe(K_IRDY, 0, "lock_in_ready");
    in_valid = 1'b0;
    probe(K_LB,   224, "lock_lower_bound");
    probe(K_TRDY, 1,   "lock_table_ready");
    for (int i = 0; i < 64; i++) probe(K_COST, i, "lock_cost", i >> 3, i & 7);

    // Reload from READY, then ramp with a gap after every word.
    pulse_reload();
    probe(K_TRDY, 0, "reload_table_ready");
    probe(K_IRDY, 1, "reload_in_ready");
    for (int i = 0; i < 64; i++) begin
      send(ramp(i));
      idle(1);
      if (i == 9) probe(K_COST, 9, "bp_partial_cost_1_1", 1, 1);
    end
    probe(K_TRDY, 1,   "bp_table_ready");
    probe(K_LB,   224, "bp_lower_bound");
    probe(K_COST, 29,  "bp_cost_3_5", 3, 5);

    // Reload mid-load: partial ramp, reload, then all 100s.
    pulse_reload();
    for (int i = 0; i < 10; i++) send(ramp(i));
    pulse_reload();
    for (int i = 0; i < 64; i++) send(100);
    probe(K_TRDY, 1,   "mid_table_ready");
    probe(K_LB,   800, "mid_lower_bound");
    for (int i = 0; i < 64; i++) probe(K_COST, 100, "mid_cost", i >> 3, i & 7);

    // Row minima on the diagonal.
    pulse_reload();
    for (int i = 0; i < 64; i++) send(diag(i));
    probe(K_LB,   36,  "diag_lower_bound");
    probe(K_COST, 8,   "diag_cost_7_7", 7, 7);
    probe(K_COST, 127, "diag_cost_2_3", 2, 3);

    // Partial load keeps old words; then async reset mid-load.
    pulse_reload();
    for (int i = 0; i < 40; i++) send(ramp(i));
    probe(K_COST, 39,  "partial_cost_4_7", 4, 7);
    probe(K_COST, 127, "partial_old_cost_5_0", 5, 0);
    probe(K_TRDY, 0,   "partial_table_ready");
    RST = 1'b1;
    #3 RST = 1'b0;
    @(posedge CLK); #1;
    probe(K_TRDY, 0, "arst_table_ready");
    probe(K_IRDY, 1, "arst_in_ready");
    probe(K_LB,   0, "arst_lower_bound");
    for (int i = 0; i < 64; i++) probe(K_COST, 0, "arst_cost", i >> 3, i & 7);
    for (int i = 0; i < 64; i++) send(diag(i));
    probe(K_TRDY, 1,  "arst_reload_table_ready");
    probe(K_LB,   36, "arst_reload_lower_bound");

    idle(2);
    if (sb.size() != 0) begin
      n_total++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/jam_cost_table.md
# jam_cost_table

Upstream cost-storage stage for the job-assignment engine. Accepts the 8×8 worker/job cost matrix as a valid/ready word stream, holds it in a register file, and serves `Cost` combinationally for the engine's `W`/`J` address pair. While loading it also computes a lower bound on the total cost: the sum of the per-worker row minima. `table_ready` tells the engine's controller when enumeration may start.

## Interface
- `N`, 8: matrix dimension; fixed at 8 (3-bit W/J).
- `COST_W`, 7: cost word width.
- `LB_W`, 10: lower-bound width (8 × 127 = 1016 fits).
- `CLK`  in  1  clock; all state changes on rising edge.
- `RST`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  `in_data` carries a cost word.
- `in_ready`  out  1  table accepts a word this cycle.
- `in_data`  in  7  cost word, row-major (W outer, J inner).
- `reload`  in  1  single-cycle pulse: restart loading from index 0.
- `W`  in  3  worker index from the engine.
- `J`  in  3  job index from the engine.
- `Cost`  out  7  `mem[W*8+J]`, combinational.
- `table_ready`  out  1  high once all 64 words are loaded.
- `LowerBound`  out  10  sum of the 8 row minima; meaningful only while `table_ready` is high.

## Operation
- States:
  - LOAD: reset state and target of `reload`.
  - READY: entered after the 64th accepted word.
- `in_ready` = (state==LOAD) & ~`reload`.
- Transfer = `in_valid` & `in_ready`. On a transfer:
  - `mem[idx]` <= `in_data`; `idx` (6-bit) increments.
  - `idx[2:0]` is J and `idx[5:3]` is W.
- Row-minimum tracking:
  - On a transfer with J==0: `row_min` <= `in_data`.
  - Otherwise: `row_min` <= min(`row_min`, `in_data`).
  - On a transfer with J==7: `lb` <= `lb` + min(`row_min`, `in_data`), zero-extended to 10 bits; no overflow is possible.
- Transfer at `idx`==63: next state READY; `idx` wraps to 0.
- READY:
  - `in_ready`=0; `in_valid` is ignored; memory and `lb` are frozen.
  - `table_ready`=1; `LowerBound`=`lb`.
- `reload` in any state: next state LOAD; `idx`<=0, `lb`<=0, `table_ready`<=0.
  - Memory is not cleared; old words persist until overwritten.
  - `reload` suppresses any same-cycle transfer.
- `Cost` reads `mem` in every state, including a partially loaded table. Reads never stall.
- Reset values:
  - `mem` all 0, so `Cost`=0.
  - `idx`=0, `row_min`=0, `lb`=0.
  - state LOAD, so `in_ready`=1 once `RST` is low.
  - `table_ready`=0, `LowerBound`=0.
- Reset mid-load: all progress is discarded and loading restarts at index 0.

## Timing
- Stream throughput: one word per cycle; back-to-back transfers allowed. Gaps in `in_valid` only stall `idx`.
- `table_ready` and `LowerBound` rise/settle on the edge that accepts word 63. A 64-cycle burst gives `table_ready`=1 in the cycle after the last handshake.
- `Cost` has zero latency from `W`/`J`. The engine registers `W`/`J` and samples `Cost` at the following edge.
- A write to `mem[a]` is visible on `Cost` from the cycle after the accepting edge, not the same cycle.
- `table_ready` falls on the edge that samples `reload`=1.

## Structure
- `jam_pkg` holds:
  - constants `N`=8, `COST_W`=7, `LB_W`=10, `IDX_W`=6;
  - the state enum {LOAD, READY}.
- The downstream assignment engine imports the same package.
- Single module; no sub-module is warranted. The min comparator and adder are inline.

## Test plan
- Ramp load: words 0..63 back-to-back → `table_ready` after 64 handshakes; `LowerBound`=224; `W`=3,`J`=5 → `Cost`=29.
- Backpressure: same data with `in_valid` toggled 1/0 → identical `LowerBound`=224; `idx` stalls on idle cycles; no word is lost.
- Reload mid-load:
  - Ramp load, then `reload` after 10 words.
  - Then 64 words of 100 → `LowerBound`=800; `Cost`=100 at every address.
- READY lockout: `in_valid`=1 with `in_data`=127 for 20 cycles after `table_ready` → `in_ready`=0; all `Cost` and `LowerBound` unchanged.
- Row minima:
  - Row W holds value 127 except J=W, which holds W+1.
  - → `LowerBound`=36; `W`=7,`J`=7 → `Cost`=8.
- Async reset mid-load:
  - Assert `RST` after 40 words.
  - → `table_ready`=0, `Cost`=0 at every address, `in_ready`=1 after release; a full reload then reproduces the expected bound.
